// File: rtl/uart_pkg.sv
// Shared types and ASCII constants for the UART case-conversion scheduler.
package uart_pkg;

    localparam int unsigned BYTE_W = 8;
    localparam int unsigned STAT_W = 16;

    typedef enum logic [1:0] {
        MODE_PASS   = 2'b00,
        MODE_UPPER  = 2'b01,
        MODE_LOWER  = 2'b10,
        MODE_TOGGLE = 2'b11
    } mode_e;

    typedef enum logic [1:0] {
        C_IDLE = 2'b00,
        C_RD   = 2'b01,
        C_WAIT = 2'b10,
        C_WR   = 2'b11
    } conv_state_e;

    typedef enum logic [1:0] {
        D_IDLE = 2'b00,
        D_RD   = 2'b01,
        D_WAIT = 2'b10,
        D_HOLD = 2'b11
    } drain_state_e;

    localparam logic [BYTE_W-1:0] CH_A_UP  = 8'h41;
    localparam logic [BYTE_W-1:0] CH_Z_UP  = 8'h5A;
    localparam logic [BYTE_W-1:0] CH_A_LO  = 8'h61;
    localparam logic [BYTE_W-1:0] CH_Z_LO  = 8'h7A;
    localparam logic [BYTE_W-1:0] CASE_BIT = 8'h20;

    function automatic logic in_range(input logic [BYTE_W-1:0] b,
                                      input logic [BYTE_W-1:0] lo,
                                      input logic [BYTE_W-1:0] hi);
        return (b >= lo) && (b <= hi);
    endfunction

endpackage

// File: rtl/ascii_case_conv.sv
// Combinational ASCII case converter; only letters A-Z / a-z are ever touched.
module ascii_case_conv
    import uart_pkg::*;
(
    input  mode_e               i_mode,
    input  logic [BYTE_W-1:0]   i_byte,
    output logic [BYTE_W-1:0]   o_byte_c
);

    logic is_up;
    logic is_lo;

    always_comb begin
        is_up    = in_range(i_byte, CH_A_UP, CH_Z_UP);
        is_lo    = in_range(i_byte, CH_A_LO, CH_Z_LO);
        o_byte_c = i_byte;
        case (i_mode)
            MODE_UPPER:  if (is_lo)          o_byte_c = i_byte & ~CASE_BIT;
            MODE_LOWER:  if (is_up)          o_byte_c = i_byte | CASE_BIT;
            MODE_TOGGLE: if (is_up || is_lo) o_byte_c = i_byte ^ CASE_BIT;
            default:                         o_byte_c = i_byte;
        endcase
    end

endmodule

// File: rtl/uart_case_sched.sv
// RX FIFO -> case conversion -> TX FIFO, plus TX FIFO -> UART drain and RTS.
// Define UART_CASE_SCHED_STATS_EN to add saturating byte/conversion counters.
module uart_case_sched
    import uart_pkg::*;
#(
    parameter int unsigned WIDTH      = 8,
    parameter int unsigned RD_TIMEOUT = 4
) (
`ifdef UART_CASE_SCHED_STATS_EN
    input  logic                i_stats_clr,
    output logic [STAT_W-1:0]   o_byte_cnt,
    output logic [STAT_W-1:0]   o_conv_cnt,
`endif
    input  logic                i_clk,
    input  logic                i_rst_n,
    input  logic [1:0]          i_mode,
    output logic                o_rx_rd_en,
    input  logic [WIDTH-1:0]    i_rx_rd_data,
    input  logic                i_rx_rd_valid,
    input  logic                i_rx_empty,
    input  logic                i_rx_almostfull,
    output logic                o_tx_wr_en,
    output logic [WIDTH-1:0]    o_tx_wr_data,
    input  logic                i_tx_full,
    output logic                o_txf_rd_en,
    input  logic [WIDTH-1:0]    i_txf_rd_data,
    input  logic                i_txf_rd_valid,
    input  logic                i_txf_empty,
    output logic [WIDTH-1:0]    o_uart_data,
    output logic                o_uart_valid,
    input  logic                i_uart_ready,
    output logic                o_rts_n,
    output logic                o_busy,
    output logic                o_err
);

    localparam int unsigned     TO_W    = (RD_TIMEOUT > 1) ? $clog2(RD_TIMEOUT) : 1;
    localparam logic [TO_W-1:0] TO_LAST = TO_W'(RD_TIMEOUT - 1);

    conv_state_e        c_state;
    drain_state_e       d_state;
    mode_e              mode_q;
    logic [TO_W-1:0]    c_cnt;
    logic [TO_W-1:0]    d_cnt;
    logic [BYTE_W-1:0]  conv_byte_c;
    logic [WIDTH-1:0]   hold_d_c;
    logic               c_to_c;
    logic               d_to_c;

    ascii_case_conv u_conv (
        .i_mode   (mode_q),
        .i_byte   (i_rx_rd_data[BYTE_W-1:0]),
        .o_byte_c (conv_byte_c)
    );

    // Upper bits beyond the ASCII byte pass straight through.
    always_comb begin
        hold_d_c               = i_rx_rd_data;
        hold_d_c[BYTE_W-1:0]   = conv_byte_c;
        c_to_c = (c_state == C_WAIT) && !i_rx_rd_valid && (c_cnt == TO_LAST);
        d_to_c = (d_state == D_WAIT) && !i_txf_rd_valid && (d_cnt == TO_LAST);
    end

    // Conversion FSM: pop RX, convert with the mode captured at pop time, push TX.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            c_state      <= C_IDLE;
            mode_q       <= MODE_PASS;
            c_cnt        <= '0;
            o_rx_rd_en   <= 1'b0;
            o_tx_wr_en   <= 1'b0;
            o_tx_wr_data <= '0;
            o_busy       <= 1'b0;
        end else begin
            o_rx_rd_en <= 1'b0;
            o_tx_wr_en <= 1'b0;
            case (c_state)
                C_IDLE: begin
                    if (!i_rx_empty) begin
                        o_rx_rd_en <= 1'b1;
                        o_busy     <= 1'b1;
                        c_state    <= C_RD;
                    end
                end
                C_RD: begin
                    mode_q  <= mode_e'(i_mode);
                    c_cnt   <= '0;
                    c_state <= C_WAIT;
                end
                C_WAIT: begin
                    if (i_rx_rd_valid) begin
                        o_tx_wr_data <= hold_d_c;
                        c_state      <= C_WR;
                    end else if (c_to_c) begin
                        o_busy  <= 1'b0;
                        c_state <= C_IDLE;
                    end else begin
                        c_cnt <= c_cnt + TO_W'(1);
                    end
                end
                C_WR: begin
                    if (!i_tx_full) begin
                        o_tx_wr_en <= 1'b1;
                        o_busy     <= 1'b0;
                        c_state    <= C_IDLE;
                    end
                end
                default: c_state <= C_IDLE;
            endcase
        end
    end

    // Drain FSM: pop TX FIFO and hold the byte on the UART until accepted.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            d_state      <= D_IDLE;
            d_cnt        <= '0;
            o_txf_rd_en  <= 1'b0;
            o_uart_data  <= '0;
            o_uart_valid <= 1'b0;
        end else begin
            o_txf_rd_en <= 1'b0;
            case (d_state)
                D_IDLE: begin
                    if (!i_txf_empty) begin
                        o_txf_rd_en <= 1'b1;
                        d_state     <= D_RD;
                    end
                end
                D_RD: begin
                    d_cnt   <= '0;
                    d_state <= D_WAIT;
                end
                D_WAIT: begin
                    if (i_txf_rd_valid) begin
                        o_uart_data  <= i_txf_rd_data;
                        o_uart_valid <= 1'b1;
                        d_state      <= D_HOLD;
                    end else if (d_to_c) begin
                        d_state <= D_IDLE;
                    end else begin
                        d_cnt <= d_cnt + TO_W'(1);
                    end
                end
                D_HOLD: begin
                    if (i_uart_ready) begin
                        o_uart_valid <= 1'b0;
                        d_state      <= D_IDLE;
                    end
                end
                default: d_state <= D_IDLE;
            endcase
        end
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            o_err   <= 1'b0;
            o_rts_n <= 1'b1;
        end else begin
            o_err   <= c_to_c | d_to_c;
            o_rts_n <= i_rx_almostfull;
        end
    end

`ifdef UART_CASE_SCHED_STATS_EN
    logic conv_diff_q;

    // Counters saturate at all-ones; clear wins over increment.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            conv_diff_q <= 1'b0;
            o_byte_cnt  <= '0;
            o_conv_cnt  <= '0;
        end else begin
            if ((c_state == C_WAIT) && i_rx_rd_valid)
                conv_diff_q <= (hold_d_c != i_rx_rd_data);
            if (i_stats_clr) begin
                o_byte_cnt <= '0;
                o_conv_cnt <= '0;
            end else if (o_tx_wr_en) begin
                if (o_byte_cnt != '1)
                    o_byte_cnt <= o_byte_cnt + STAT_W'(1);
                if (conv_diff_q && (o_conv_cnt != '1))
                    o_conv_cnt <= o_conv_cnt + STAT_W'(1);
            end
        end
    end
`endif

endmodule

// File: doc/uart_case_sched.md
Name: uart_case_sched

Overview:
- Controller between the RX FIFO, the TX FIFO and the UART transmitter.
- Pops bytes from the RX FIFO, applies the selected ASCII case conversion, pushes the result into the TX FIFO, and drains the TX FIFO into the transmitter with a valid/ready handshake.
- Also drives RTS flow control from the RX FIFO almost-full flag.
- Sits between the UART receiver/transmitter FIFOs in the top level.

Parameters:
- WIDTH, 8, data width; conversion applies to bits [7:0], upper bits pass through unchanged.
- RD_TIMEOUT, 4, cycles to wait for a FIFO read-valid before abandoning the read.

Ports:
- i_clk  in  1  system clock
- i_rst_n  in  1  asynchronous active-low reset
- i_mode  in  2  00 pass, 01 upper, 10 lower, 11 toggle
- o_rx_rd_en  out  1  RX FIFO pop strobe
- i_rx_rd_data  in  WIDTH  RX FIFO read data
- i_rx_rd_valid  in  1  RX FIFO read data valid
- i_rx_empty  in  1  RX FIFO empty
- i_rx_almostfull  in  1  RX FIFO almost full
- o_tx_wr_en  out  1  TX FIFO push strobe
- o_tx_wr_data  out  WIDTH  TX FIFO write data
- i_tx_full  in  1  TX FIFO full
- o_txf_rd_en  out  1  TX FIFO pop strobe (drain side)
- i_txf_rd_data  in  WIDTH  TX FIFO read data
- i_txf_rd_valid  in  1  TX FIFO read data valid
- i_txf_empty  in  1  TX FIFO empty
- o_uart_data  out  WIDTH  byte to transmitter
- o_uart_valid  out  1  byte valid
- i_uart_ready  in  1  transmitter accepts byte
- o_rts_n  out  1  low = peer may send
- o_busy  out  1  conversion FSM not in C_IDLE
- o_err  out  1  one-cycle pulse on read timeout

Behaviour:
- Reset (async, i_rst_n=0):
  - All strobes, o_uart_valid, o_busy and o_err are 0.
  - o_rts_n=1; both FSMs are in IDLE; data registers are 0.
- o_rts_n: registered copy of i_rx_almostfull, one cycle latency.
- Conversion FSM (C_IDLE, C_RD, C_WAIT, C_WR):
  - C_IDLE: if !i_rx_empty, go to C_RD.
  - C_RD: o_rx_rd_en=1 for exactly one cycle; i_mode is latched into the mode register; go to C_WAIT.
  - C_WAIT: on i_rx_rd_valid, latch the converted data into the hold register and go to C_WR. After RD_TIMEOUT cycles without valid, pulse o_err and go to C_IDLE.
  - C_WR: when !i_tx_full, o_tx_wr_en=1 for one cycle with o_tx_wr_data=hold, then go to C_IDLE. While full, stay in C_WR with data held.
- Minimum throughput: one byte per 4 cycles (IDLE→RD→WAIT→WR).
- Conversion rules:
  - Upper: 0x61..0x7A has bit5 cleared.
  - Lower: 0x41..0x5A has bit5 set.
  - Toggle: both ranges have bit5 flipped.
  - All other bytes, and pass mode, are unchanged.
  - Boundaries: 0x60, 0x7B, 0x40 and 0x5B are never modified.
- i_mode changes mid-byte do not affect the byte in flight; the mode latched in C_RD is used.
- Drain FSM (D_IDLE, D_RD, D_WAIT, D_HOLD), independent of the conversion FSM:
  - D_IDLE: if !i_txf_empty, go to D_RD.
  - D_RD: o_txf_rd_en=1 for one cycle.
  - D_WAIT: on i_txf_rd_valid, load o_uart_data, set o_uart_valid=1 and go to D_HOLD. Timeout behaves as in the conversion FSM and shares o_err; the two pulses are ORed.
  - D_HOLD: o_uart_data is stable while valid; on i_uart_ready, clear valid and go to D_IDLE.
- Simultaneous events: a TX push and a TX pop in the same cycle are legal; the FIFO handles them.
- Strobes never assert while the corresponding full/empty flag is set in that cycle.
- Reset asserted mid-operation aborts any in-flight byte; no strobe is issued after reset.

Optional Feature:
- Macro: UART_CASE_SCHED_STATS_EN.
- Defined:
  - Adds outputs o_byte_cnt[15:0] and o_conv_cnt[15:0].
  - o_byte_cnt increments on every o_tx_wr_en.
  - o_conv_cnt increments when the pushed byte differs from the popped byte.
  - Both counters are saturating, reset to 0, and cleared by input i_stats_clr (synchronous, takes priority over increment).
- Undefined: these ports and registers do not exist.

Decomposition:
- Package uart_pkg holds:
  - mode typedef (MODE_PASS, MODE_UPPER, MODE_LOWER, MODE_TOGGLE).
  - State typedefs for both FSMs.
  - ASCII constants: CH_A_UP=0x41, CH_Z_UP=0x5A, CH_A_LO=0x61, CH_Z_LO=0x7A, CASE_BIT=0x20.
- Sub-module ascii_case_conv: combinational (mode, byte in → byte out). It is instantiated once and verified standalone.

Test Plan:
- Reset, then RX FIFO holds "aZ1" with mode=01 → TX FIFO receives 0x41, 0x5A, 0x31; o_err=0; o_uart sequence A, Z, 1 with ready tied 1.
- mode=11 with bytes 0x40, 0x41, 0x5B, 0x60, 0x61, 0x7B → 0x40, 0x61, 0x5B, 0x60, 0x41, 0x7B.
- i_tx_full held 10 cycles during C_WR → o_tx_wr_en stays 0 and o_tx_wr_data holds; exactly one push after full deasserts.
- i_uart_ready low for 5 cycles → o_uart_valid and o_uart_data stable; one byte transferred on ready; no extra TX pop.
- RX pop with i_rx_rd_valid withheld → o_err pulses once, 4 cycles after C_WAIT entry; FSM returns to C_IDLE; no push occurs.
- Reset asserted in C_WR, and separately i_rx_almostfull=1 → all strobes 0, state C_IDLE; o_rts_n=1 one cycle after almostfull.
